ws2812_frame_scheduler: RTL and testbench
=========================================

// Module: ws2812_frame_scheduler
// PURPOSE
//  Owns the colour state of a WS2812 strip and decides when a frame is sent.
//  Holds one 24-bit GRB word per LED. Arbitrates writes from a host port and a status port.
//  Streams the frame, LED 0 first, over valid/ready to the downstream bit serialiser,
//  then enforces the latch gap. Sits between the system/status logic and the serialiser.
// PARAMETERS
//  NUM_LEDS        8          LEDs on the strip (>=1)
//  ADDR_W          3          LED index width; must satisfy 2**ADDR_W >= NUM_LEDS
//  LATCH_CYCLES    9900       low gap after the last pixel (>=300us at 32.94MHz)
//  REFRESH_CYCLES  3294000    idle period after which a frame is resent unchanged (100ms)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high
//  host_we     in   1       host write strobe; always accepted
//  host_addr   in   ADDR_W  LED index for host write
//  host_data   in   24      GRB colour for host write
//  stat_valid  in   1       status-port write request
//  stat_ready  out  1       status write accepted this cycle
//  stat_addr   in   ADDR_W  LED index for status write
//  stat_data   in   24      GRB colour for status write
//  pix_valid   out  1       pixel word valid to serialiser
//  pix_ready   in   1       serialiser accepts pixel
//  pix_data    out  24      GRB pixel
//  frame_start out  1       1-cycle pulse when a frame begins
//  frame_done  out  1       1-cycle pulse when the latch gap ends
//  busy        out  1       high in CLEAR, STREAM and LATCH
// BEHAVIOUR
//  Reset: all outputs are 0, except busy=1 because state goes to CLEAR. idx=0, dirty=1, counters=0.
//  CLEAR: writes 0 to RAM[idx], one entry per cycle, for NUM_LEDS cycles.
//    Port writes are ignored and stat_ready=0. Then goes to IDLE with dirty=1.
//  Arbitration, in IDLE/STREAM/LATCH:
//    host_we always wins.
//    stat_ready = stat_valid & ~host_we. It is combinational; the transfer is stat_valid & stat_ready.
//    An accepted write to an address >= NUM_LEDS is dropped: no RAM update, dirty unchanged.
//    Any other accepted write updates the RAM entry and sets dirty.
//  IDLE:
//    If dirty, or refresh_cnt == REFRESH_CYCLES-1: pulse frame_start, clear dirty,
//    set idx=0, clear refresh_cnt, go to STREAM. Otherwise refresh_cnt increments.
//    A write in the same cycle as the start is captured and re-sets dirty (write beats clear).
//  STREAM:
//    The RAM read is registered, so pix_valid rises 1 cycle after frame_start.
//    pix_data and pix_valid stay stable until pix_ready.
//    On handshake, idx increments and the next word is presented the following cycle
//    (1 bubble per pixel is permitted).
//    After the NUM_LEDS-1 handshake: pix_valid=0, latch_cnt=0, go to LATCH.
//    A write during STREAM sets dirty. If it targets an idx not yet read it also appears in
//    this frame; either way a new frame follows the latch.
//  LATCH: counts LATCH_CYCLES cycles, then pulses frame_done and goes to IDLE.
//    pix_valid=0 throughout.
//  Widths: refresh_cnt and latch_cnt are $clog2(max)+1 bits and saturate-free (never wrap).
//  Reset mid-frame: pix_valid drops the next cycle, RAM is re-cleared, and no frame_done is issued.
//  Serialiser stall (pix_ready=0 indefinitely): the block waits in STREAM.
//    Writes are still accepted and the refresh counter is held.
// STRUCTURE
//  Package ws2812_pkg: grb_t (24-bit), state encoding {CLEAR, IDLE, STREAM, LATCH},
//    default timing constants.
//  Sub-module ws2812_color_ram: NUM_LEDS x 24 RAM with 1 write port and 1 registered read port.
//  The FSM, arbiter and counters stay in this module.
// TESTING
//  1. Reset, pix_ready=1: NUM_LEDS cycles of CLEAR, then 8 pixels all 0x000000,
//     frame_done after 9900 cycles.
//  2. Host writes addr2=0xFF0000 while IDLE: frame_start the next cycle;
//     the 3rd pixel equals 0xFF0000 and the others are 0.
//  3. host_we and stat_valid in the same cycle: stat_ready=0; the host value is stored;
//     the status write completes the following cycle.
//  4. Write during STREAM to an already-sent idx: the current frame has the old value;
//     a second frame with the new value starts right after frame_done.
//  5. No writes: frames repeat every REFRESH_CYCLES idle cycles. Write to addr 9 (>=NUM_LEDS)
//     is accepted, and no extra frame starts.
//  6. pix_ready held low for 50 cycles mid-frame: pix_data is stable and nothing is lost.
//     Assert reset mid-STREAM: pix_valid=0 next cycle and CLEAR restarts.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame scheduler slice.
package ws2812_pkg;

    typedef logic [23:0] grb_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        STREAM,
        LATCH
    } state_t;

    localparam int DEF_NUM_LEDS       = 8;
    localparam int DEF_ADDR_W         = 3;
    localparam int DEF_LATCH_CYCLES   = 9900;
    localparam int DEF_REFRESH_CYCLES = 3294000;

endpackage

// File: rtl/ws2812_color_ram.sv
// Per-LED colour store: one write port, one registered read port with read enable.
module ws2812_color_ram
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  grb_t              wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output grb_t              rdata
);

    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    grb_t mem [2**IW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Read data is held between enables so a stalled pixel stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr[IW-1:0]];
        end
    end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Holds the strip colour state, arbitrates host/status writes and streams
// frames to the bit serialiser followed by the latch gap.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS       = DEF_NUM_LEDS,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [23:0]       host_data,
    input  logic              stat_valid,
    output logic              stat_ready,
    input  logic [ADDR_W-1:0] stat_addr,
    input  logic [23:0]       stat_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam int RW = $clog2(REFRESH_CYCLES) + 1;
    localparam int LW = $clog2(LATCH_CYCLES) + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_LEDS_W   = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [RW-1:0]     REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [LW-1:0]     LATCH_LAST   = LW'(LATCH_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              dirty;
    logic [RW-1:0]     refresh_cnt;
    logic [LW-1:0]     latch_cnt;

    logic [ADDR_W-1:0] wr_addr;
    grb_t              wr_data;
    logic              wr_accept;
    logic              wr_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    grb_t              ram_wdata;
    logic              ram_re;

    always_comb begin
        stat_ready = stat_valid & ~host_we & (state != CLEAR);
        wr_accept  = (state != CLEAR) & (host_we | stat_valid);
        wr_addr    = host_we ? host_addr : stat_addr;
        wr_data    = host_we ? host_data : stat_data;
        wr_hit     = wr_accept & ({1'b0, wr_addr} < NUM_LEDS_W);
        ram_we     = (state == CLEAR) | wr_hit;
        ram_waddr  = (state == CLEAR) ? idx : wr_addr;
        ram_wdata  = (state == CLEAR) ? '0 : wr_data;
        ram_re     = (state == STREAM) & ~pix_valid;
    end

    assign busy = (state != IDLE);

    ws2812_color_ram #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (idx),
        .rdata (pix_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            idx         <= '0;
            dirty       <= 1'b1;
            refresh_cnt <= '0;
            latch_cnt   <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (wr_hit) begin
                dirty <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        dirty <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                IDLE: begin
                    if (dirty || refresh_cnt == REFRESH_LAST) begin
                        frame_start <= 1'b1;
                        // A write landing on the start cycle keeps dirty set.
                        dirty       <= wr_hit;
                        idx         <= '0;
                        refresh_cnt <= '0;
                        state       <= STREAM;
                    end else begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (!pix_valid) begin
                        pix_valid <= 1'b1;
                    end else if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            latch_cnt <= '0;
                            state     <= LATCH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench: stimulus queues expected pixel frames, a negedge monitor pops and compares.
module tb_ws2812_frame_scheduler;

    localparam int N       = 8;
    localparam int AW      = 4;
    localparam int LATCH   = 40;
    localparam int REFRESH = 300;
    localparam int BOUND   = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [23:0]   host_data;
    logic          stat_valid;
    logic          stat_ready;
    logic [AW-1:0] stat_addr;
    logic [23:0]   stat_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   pix_data;
    logic          frame_start;
    logic          frame_done;
    logic          busy;

    ws2812_frame_scheduler #(
        .NUM_LEDS       (N),
        .ADDR_W         (AW),
        .LATCH_CYCLES   (LATCH),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .stat_valid  (stat_valid),
        .stat_ready  (stat_ready),
        .stat_addr   (stat_addr),
        .stat_data   (stat_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_start  = 0;
    int          n_done   = 0;
    int          n_pix    = 0;
    int          start_cyc = 0;
    int          done_cyc  = 0;
    logic [23:0] model [N];
    logic [23:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic expect_frame();
        for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [23:0] d);
        @(posedge clk); #1;
        host_we = 1'b1; host_addr = a; host_data = d;
        @(posedge clk); #1;
        host_we = 1'b0;
        if (a < N) model[a] = d;
    endtask

    task automatic wait_starts(input int target, input string name);
        int t = 0;
        while (n_start < target && t < BOUND) begin @(posedge clk); t++; end
        check(name, 32'(n_start), 32'(target));
    endtask

    task automatic wait_dones(input int target, input string name);
        int t = 0;
        while (n_done < target && t < BOUND) begin @(posedge clk); t++; end
        check(name, 32'(n_done), 32'(target));
    endtask

    task automatic wait_pix(input int target, input string name);
        int t = 0;
        while (n_pix < target && t < BOUND) begin @(posedge clk); t++; end
        check(name, 32'(n_pix >= target), 32'(1));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pixel scoreboard, stall stability and frame event capture.
    initial begin
        logic        prev_stall = 1'b0;
        logic [23:0] prev_data  = '0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(pix_valid), 32'(1));
                    check("stall_data", 32'(pix_data), 32'(prev_data));
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pixel: got %06h, expected none (cycle %0d)", pix_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(pix_data), 32'(e));
                    end
                    n_pix++;
                end
                if (frame_start) begin n_start++; start_cyc = cyc; end
                if (frame_done)  begin n_done++;  done_cyc  = cyc; end
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
            end
        end
    end

    initial begin
        int rel_cyc;
        int base;
        int d_before;
        reset = 1'b1; host_we = 1'b0; host_addr = '0; host_data = '0;
        stat_valid = 1'b0; stat_addr = '0; stat_data = '0; pix_ready = 1'b1;
        for (int i = 0; i < N; i++) model[i] = '0;

        // 1: reset values, CLEAR length, all-zero first frame, latch gap
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_valid", 32'(pix_valid), 32'(0));
        check("rst_pix_data", 32'(pix_data), 32'(0));
        check("rst_frame_start", 32'(frame_start), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_stat_ready", 32'(stat_ready), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        rel_cyc = cyc;
        expect_frame();
        wait_starts(1, "t1_start_timeout");
        check("t1_clear_len", 32'(start_cyc - rel_cyc), 32'(N + 1));
        wait_dones(1, "t1_done_timeout");
        check("t1_frame_len", 32'(done_cyc - start_cyc), 32'(2 * N + LATCH));
        #1;
        check("t1_idle_busy", 32'(busy), 32'(0));

        // 2: single host write while idle
        host_write(AW'(2), 24'hFF0000);
        expect_frame();
        wait_starts(2, "t2_start_timeout");
        wait_dones(2, "t2_done_timeout");

        // 3: host and status collide; status lands on the start cycle
        @(posedge clk); #1;
        host_we = 1'b1; host_addr = AW'(5); host_data = 24'h00AA00;
        stat_valid = 1'b1; stat_addr = AW'(6); stat_data = 24'h0000BB;
        @(negedge clk);
        check("t3_ready_blocked", 32'(stat_ready), 32'(0));
        @(posedge clk); #1;
        host_we = 1'b0;
        @(negedge clk);
        check("t3_ready_free", 32'(stat_ready), 32'(1));
        @(posedge clk); #1;
        stat_valid = 1'b0;
        model[5] = 24'h00AA00;
        model[6] = 24'h0000BB;
        expect_frame();
        expect_frame();
        wait_starts(4, "t3_start_timeout");
        wait_dones(4, "t3_done_timeout");

        // 4: overwrite an already-sent pixel mid-frame
        base = n_pix;
        host_write(AW'(0), 24'h123456);
        expect_frame();
        wait_pix(base + 2, "t4_pix_timeout");
        host_write(AW'(0), 24'h654321);
        expect_frame();
        wait_dones(5, "t4_done_timeout");
        wait_starts(6, "t4_start2_timeout");
        check("t4_back_to_back", 32'(start_cyc - done_cyc), 32'(1));
        wait_dones(6, "t4_done2_timeout");

        // 5: refresh period and dropped out-of-range writes
        expect_frame();
        wait_starts(7, "t5_refresh_timeout");
        check("t5_refresh_gap", 32'(start_cyc - done_cyc), 32'(REFRESH));
        wait_dones(7, "t5_done_timeout");
        host_write(AW'(9), 24'hABCDEF);
        @(posedge clk); #1;
        stat_valid = 1'b1; stat_addr = AW'(9); stat_data = 24'h111111;
        @(negedge clk);
        check("t5_stat_accept_oob", 32'(stat_ready), 32'(1));
        @(posedge clk); #1;
        stat_valid = 1'b0;
        expect_frame();
        wait_starts(8, "t5_refresh2_timeout");
        check("t5_no_extra_frame", 32'(start_cyc - done_cyc), 32'(REFRESH));
        wait_dones(8, "t5_done2_timeout");

        // 6: long stall mid-frame, then reset mid-stream
        base = n_pix;
        host_write(AW'(3), 24'h0A0B0C);
        expect_frame();
        wait_pix(base + 3, "t6_pix_timeout");
        #1;
        pix_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        pix_ready = 1'b1;
        wait_pix(base + 5, "t6_pix2_timeout");
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_rst_pix_valid", 32'(pix_valid), 32'(0));
        check("t6_rst_busy", 32'(busy), 32'(1));
        rel_cyc  = cyc;
        d_before = n_done;
        exp_q.delete();
        for (int i = 0; i < N; i++) model[i] = '0;
        expect_frame();
        wait_starts(n_start + 1, "t6_start_timeout");
        check("t6_clear_len", 32'(start_cyc - rel_cyc), 32'(N + 1));
        check("t6_no_done_on_abort", 32'(n_done), 32'(d_before));
        wait_dones(d_before + 1, "t6_done_timeout");
        check("t6_frame_len", 32'(done_cyc - start_cyc), 32'(2 * N + LATCH));
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
